// File: rtl/dual_issue_queue_pkg.sv
// Shared types for the fetch/decode instruction queue: predecode bundle layout
// and the issue-mode encoding consumed by the slot-2 forwarding logic.
package dual_issue_queue_pkg;

    localparam int unsigned REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    // Field order is MSB-first: we, waddr, re1, raddr1, re2, raddr2, is_br, is_mem, is_hilo
    typedef struct packed {
        logic      we;
        reg_addr_t waddr;
        logic      re1;
        reg_addr_t raddr1;
        logic      re2;
        reg_addr_t raddr2;
        logic      is_br;
        logic      is_mem;
        logic      is_hilo;
    } meta_t;

    localparam int unsigned META_BITS = $bits(meta_t);

    typedef enum logic {
        ISSUE_SINGLE = 1'b0,
        ISSUE_DUAL   = 1'b1
    } issue_e;

    // Slot 2 reads a register slot 1 writes; $0 never carries a dependency.
    function automatic logic raw_dep(input meta_t older, input meta_t younger);
        return older.we && (older.waddr != '0) &&
               ((younger.re1 && (younger.raddr1 == older.waddr)) ||
                (younger.re2 && (younger.raddr2 == older.waddr)));
    endfunction

endpackage

// File: rtl/dual_issue_queue_hazard.sv
// Pairing check for the two oldest queue entries: decides single vs dual issue.
module dual_issue_hazard
    import dual_issue_queue_pkg::*;
(
    input  logic [META_BITS-1:0] i_meta1,
    input  logic [META_BITS-1:0] i_meta2,
    input  logic                 i_both_valid,
    output logic                 o_issue_mode
);

    meta_t  w_m1;
    meta_t  w_m2;
    issue_e w_mode;

    assign w_m1 = meta_t'(i_meta1);
    assign w_m2 = meta_t'(i_meta2);

    // A branch in slot 1 may pair with its delay slot; a branch in slot 2 may not.
    always_comb begin
        w_mode = ISSUE_DUAL;
        if (!i_both_valid)                 w_mode = ISSUE_SINGLE;
        if (raw_dep(w_m1, w_m2))           w_mode = ISSUE_SINGLE;
        if (w_m1.is_mem && w_m2.is_mem)    w_mode = ISSUE_SINGLE;
        if (w_m1.is_hilo && w_m2.is_hilo)  w_mode = ISSUE_SINGLE;
        if (w_m2.is_br)                    w_mode = ISSUE_SINGLE;
    end

    assign o_issue_mode = (w_mode == ISSUE_DUAL);

endmodule

// File: rtl/dual_issue_queue.sv
// Circular instruction buffer between fetch and decode: accepts up to two entries
// per cycle, presents the two oldest and pops 0/1/2 per the pairing decision.
module dual_issue_queue
    import dual_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned META_W = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [3:0]        stall,
    input  logic              in_valid0,
    input  logic              in_valid1,
    input  logic [PC_W-1:0]   in_pc0,
    input  logic [PC_W-1:0]   in_pc1,
    input  logic [INST_W-1:0] in_inst0,
    input  logic [INST_W-1:0] in_inst1,
    input  logic [META_W-1:0] in_meta0,
    input  logic [META_W-1:0] in_meta1,
    output logic              in_ready,
    output logic              out_valid1,
    output logic [PC_W-1:0]   out_pc1,
    output logic [INST_W-1:0] out_inst1,
    output logic [META_W-1:0] out_meta1,
    output logic              out_valid2,
    output logic [PC_W-1:0]   out_pc2,
    output logic [INST_W-1:0] out_inst2,
    output logic [META_W-1:0] out_meta2,
    output logic              issue_mode
);

    logic [PC_W-1:0]   r_pc   [DEPTH];
    logic [INST_W-1:0] r_inst [DEPTH];
    logic [META_W-1:0] r_meta [DEPTH];

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;

    logic [1:0]    w_push_n;
    logic [1:0]    w_pop_n;
    logic [AW-1:0] w_head2;
    logic [AW-1:0] w_tail1;
    logic          w_issue;
    logic          w_unused_stall;

    assign w_unused_stall = ^{stall[3:2], stall[0]};

    assign in_ready = ~rst & (r_count <= (AW+1)'(DEPTH-2));
    assign w_head2  = r_head + AW'(1);
    assign w_tail1  = r_tail + AW'(1);

    always_comb begin
        w_push_n = '0;
        if (in_ready && in_valid0) w_push_n = in_valid1 ? 2'd2 : 2'd1;
    end

    assign out_valid1 = (r_count != '0);
    assign out_pc1    = r_pc[r_head];
    assign out_inst1  = r_inst[r_head];
    assign out_meta1  = r_meta[r_head];
    assign out_pc2    = r_pc[w_head2];
    assign out_inst2  = r_inst[w_head2];
    assign out_meta2  = r_meta[w_head2];

    dual_issue_hazard u_hazard (
        .i_meta1      (out_meta1),
        .i_meta2      (out_meta2),
        .i_both_valid (r_count >= (AW+1)'(2)),
        .o_issue_mode (w_issue)
    );

    assign issue_mode = w_issue;
    assign out_valid2 = w_issue;

    always_comb begin
        w_pop_n = '0;
        if (!stall[1]) w_pop_n = w_issue ? 2'd2 : {1'b0, out_valid1};
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_pop_n);
            r_tail  <= r_tail + AW'(w_push_n);
            r_count <= r_count + (AW+1)'(w_push_n) - (AW+1)'(w_pop_n);
        end
    end

    // Storage is not reset; a flushed push is suppressed so stale slots stay untouched.
    always_ff @(posedge clk) begin
        if (!flush && (w_push_n != '0)) begin
            r_pc[r_tail]   <= in_pc0;
            r_inst[r_tail] <= in_inst0;
            r_meta[r_tail] <= in_meta0;
            if (w_push_n == 2'd2) begin
                r_pc[w_tail1]   <= in_pc1;
                r_inst[w_tail1] <= in_inst1;
                r_meta[w_tail1] <= in_meta1;
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_queue.sv
// Scoreboard bench for dual_issue_queue: accepted entries are queued in order and
// checked against the slot-1/slot-2 outputs as decode pops them.
module tb_dual_issue_queue;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [20:0] meta;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [3:0]  stall = 4'b0;
    logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic [31:0] in_pc0 = '0, in_pc1 = '0, in_inst0 = '0, in_inst1 = '0;
    logic [20:0] in_meta0 = '0, in_meta1 = '0;
    logic        in_ready, out_valid1, out_valid2, issue_mode;
    logic [31:0] out_pc1, out_pc2, out_inst1, out_inst2;
    logic [20:0] out_meta1, out_meta2;

    ent_t        sb[$];
    ent_t        z = '0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] pc_seq = 32'h0000_1000;

    always #5 clk = ~clk;

    dual_issue_queue #(.DEPTH(16), .AW(4), .PC_W(32), .INST_W(32), .META_W(21)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid0(in_valid0), .in_valid1(in_valid1),
        .in_pc0(in_pc0), .in_pc1(in_pc1), .in_inst0(in_inst0), .in_inst1(in_inst1),
        .in_meta0(in_meta0), .in_meta1(in_meta1), .in_ready(in_ready),
        .out_valid1(out_valid1), .out_pc1(out_pc1), .out_inst1(out_inst1), .out_meta1(out_meta1),
        .out_valid2(out_valid2), .out_pc2(out_pc2), .out_inst2(out_inst2), .out_meta2(out_meta2),
        .issue_mode(issue_mode)
    );

    function automatic logic [20:0] mk(input logic we, input logic [4:0] wa, input logic r1e,
                                       input logic [4:0] r1, input logic r2e, input logic [4:0] r2,
                                       input logic br, input logic mem, input logic hilo);
        return {we, wa, r1e, r1, r2e, r2, br, mem, hilo};
    endfunction

    function automatic logic model_issue();
        logic [20:0] a, b;
        logic dep;
        if (sb.size() < 2) return 1'b0;
        a = sb[0].meta;
        b = sb[1].meta;
        dep = a[20] && (a[19:15] != 5'd0) &&
              ((b[14] && b[13:9] == a[19:15]) || (b[8] && b[7:3] == a[19:15]));
        return !dep && !(a[1] && b[1]) && !(a[0] && b[0]) && !b[2];
    endfunction

    task automatic mk_ent(input logic [20:0] m, output ent_t e);
        e.pc   = pc_seq;
        e.inst = $urandom;
        e.meta = m;
        pc_seq = pc_seq + 32'd4;
    endtask

    task automatic tick(input logic v0, input logic v1, input ent_t e0, input ent_t e1,
                        input logic [3:0] st, input logic fl);
        logic acc;
        int   npop;
        in_valid0 = v0; in_valid1 = v1;
        in_pc0 = e0.pc; in_inst0 = e0.inst; in_meta0 = e0.meta;
        in_pc1 = e1.pc; in_inst1 = e1.inst; in_meta1 = e1.meta;
        stall = st; flush = fl;
        acc  = !rst && (sb.size() <= 14);
        npop = st[1] ? 0 : (model_issue() ? 2 : (sb.size() >= 1 ? 1 : 0));
        @(posedge clk);
        if (rst || fl) begin
            sb.delete();
        end else begin
            repeat (npop) void'(sb.pop_front());
            if (acc && v0) begin
                sb.push_back(e0);
                if (v1) sb.push_back(e1);
            end
        end
        @(negedge clk);
        in_valid0 = 1'b0; in_valid1 = 1'b0; flush = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) tick(1'b0, 1'b0, z, z, 4'b0000, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0, z, z, 4'b0000, 1'b0);
        tick(1'b0, 1'b0, z, z, 4'b0000, 1'b0);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL reset out_valid1: got %b want 0", out_valid1); end
        n_cmp++; if (issue_mode !== 1'b0) begin n_err++; $display("FAIL reset issue_mode: got %b want 0", issue_mode); end
        n_cmp++; if (out_valid2 !== 1'b0) begin n_err++; $display("FAIL reset out_valid2: got %b want 0", out_valid2); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_dual_alu();
        ent_t a, b;
        mk_ent(mk(1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 0), a);
        mk_ent(mk(1, 5'd2, 1, 5'd4, 1, 5'd5, 0, 0, 0), b);
        tick(1'b1, 1'b1, a, b, 4'b0000, 1'b0);
        n_cmp++; if (out_valid1 !== 1'b1) begin n_err++; $display("FAIL dual_alu out_valid1: got %b want 1", out_valid1); end
        n_cmp++; if (issue_mode !== 1'b1) begin n_err++; $display("FAIL dual_alu issue_mode: got %b want 1", issue_mode); end
        n_cmp++; if (out_pc1 !== sb[0].pc) begin n_err++; $display("FAIL dual_alu pc1: got %h want %h", out_pc1, sb[0].pc); end
        n_cmp++; if (out_pc2 !== sb[1].pc) begin n_err++; $display("FAIL dual_alu pc2: got %h want %h", out_pc2, sb[1].pc); end
        n_cmp++; if (out_inst1 !== a.inst) begin n_err++; $display("FAIL dual_alu inst1: got %h want %h", out_inst1, a.inst); end
        n_cmp++; if (out_meta2 !== b.meta) begin n_err++; $display("FAIL dual_alu meta2: got %h want %h", out_meta2, b.meta); end
        tick(1'b0, 1'b0, z, z, 4'b0000, 1'b0);
        n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL dual_alu empty_after_pop: got %b want 0", out_valid1); end
    endtask

    task automatic test_raw();
        ent_t a, b;
        mk_ent(mk(1, 5'd3, 1, 5'd1, 1, 5'd2, 0, 0, 0), a);
        mk_ent(mk(1, 5'd4, 1, 5'd3, 1, 5'd0, 0, 0, 0), b);
        tick(1'b1, 1'b1, a, b, 4'b0000, 1'b0);
        n_cmp++; if (issue_mode !== 1'b0) begin n_err++; $display("FAIL raw issue_mode: got %b want 0", issue_mode); end
        n_cmp++; if (out_valid2 !== 1'b0) begin n_err++; $display("FAIL raw out_valid2: got %b want 0", out_valid2); end
        tick(1'b0, 1'b0, z, z, 4'b0000, 1'b0);
        n_cmp++; if (out_valid1 !== 1'b1) begin n_err++; $display("FAIL raw single_pop valid1: got %b want 1", out_valid1); end
        n_cmp++; if (out_pc1 !== b.pc) begin n_err++; $display("FAIL raw slot2_promoted pc1: got %h want %h", out_pc1, b.pc); end
        drain();
    endtask

    task automatic test_zero_reg();
        ent_t a, b;
        mk_ent(mk(1, 5'd0, 1, 5'd1, 0, 5'd0, 0, 0, 0), a);
        mk_ent(mk(1, 5'd5, 1, 5'd0, 1, 5'd0, 0, 0, 0), b);
        tick(1'b1, 1'b1, a, b, 4'b0000, 1'b0);
        n_cmp++; if (issue_mode !== 1'b1) begin n_err++; $display("FAIL zero_reg issue_mode: got %b want 1", issue_mode); end
        drain();
    endtask

    task automatic test_pairs();
        logic [20:0] m1 [4];
        logic [20:0] m2 [4];
        logic        ex [4];
        ent_t a, b;
        m1[0] = mk(1, 5'd6, 1, 5'd29, 0, 5'd0, 0, 1, 0);  m2[0] = mk(1, 5'd7, 1, 5'd29, 0, 5'd0, 0, 1, 0);  ex[0] = 1'b0;
        m1[1] = mk(1, 5'd8, 1, 5'd1, 1, 5'd2, 0, 0, 0);   m2[1] = mk(0, 5'd0, 1, 5'd9, 1, 5'd10, 1, 0, 0); ex[1] = 1'b0;
        m1[2] = mk(0, 5'd0, 1, 5'd9, 1, 5'd10, 1, 0, 0);  m2[2] = mk(1, 5'd11, 1, 5'd1, 1, 5'd2, 0, 0, 0); ex[2] = 1'b1;
        m1[3] = mk(0, 5'd0, 1, 5'd1, 1, 5'd2, 0, 0, 1);   m2[3] = mk(1, 5'd12, 0, 5'd0, 0, 5'd0, 0, 0, 1); ex[3] = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            mk_ent(m1[i], a);
            mk_ent(m2[i], b);
            tick(1'b1, 1'b1, a, b, 4'b0000, 1'b0);
            n_cmp++;
            if (issue_mode !== ex[i]) begin
                n_err++; $display("FAIL pair%0d issue_mode: got %b want %b", i, issue_mode, ex[i]);
            end
            drain();
        end
    endtask

    task automatic test_back_to_back();
        ent_t a, b;
        logic mi;
        for (int unsigned i = 0; i < 7; i++) begin
            mk_ent(mk(1, 5'(i + 1), 1, 5'd20, 0, 5'd0, 0, 0, 0), a);
            mk_ent(mk(1, 5'(i + 10), 1, 5'd21, 0, 5'd0, 0, (i % 3 == 2), 0), b);
            tick(1'b1, 1'b1, a, b, 4'b0010, 1'b0);
        end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill14 in_ready: got %b want 1", in_ready); end
        mk_ent(mk(1, 5'd15, 0, 5'd0, 0, 5'd0, 0, 1, 0), a);
        mk_ent(mk(1, 5'd16, 0, 5'd0, 0, 5'd0, 0, 1, 0), b);
        tick(1'b1, 1'b1, a, b, 4'b0010, 1'b0);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full16 in_ready: got %b want 0", in_ready); end
        mk_ent(mk(1, 5'd17, 0, 5'd0, 0, 5'd0, 0, 0, 0), a);
        mk_ent(mk(1, 5'd18, 0, 5'd0, 0, 5'd0, 0, 0, 0), b);
        tick(1'b1, 1'b1, a, b, 4'b0010, 1'b0);
        n_cmp++; if (sb.size() != 16) begin n_err++; $display("FAIL full_drop model_size: got %0d want 16", sb.size()); end
        for (int cyc = 0; cyc < 40 && sb.size() > 0; cyc++) begin
            mi = model_issue();
            n_cmp++; if (out_valid1 !== 1'b1) begin n_err++; $display("FAIL drain valid1 cyc%0d: got %b want 1", cyc, out_valid1); end
            n_cmp++; if (out_pc1 !== sb[0].pc) begin n_err++; $display("FAIL drain pc1 cyc%0d: got %h want %h", cyc, out_pc1, sb[0].pc); end
            n_cmp++; if (issue_mode !== mi) begin n_err++; $display("FAIL drain issue cyc%0d: got %b want %b", cyc, issue_mode, mi); end
            if (mi) begin
                n_cmp++; if (out_pc2 !== sb[1].pc) begin n_err++; $display("FAIL drain pc2 cyc%0d: got %h want %h", cyc, out_pc2, sb[1].pc); end
            end
            tick(1'b0, 1'b0, z, z, 4'b0000, 1'b0);
        end
        n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL drain_end valid1: got %b want 0", out_valid1); end
    endtask

    task automatic test_flush();
        ent_t a, b;
        for (int unsigned i = 0; i < 3; i++) begin
            mk_ent(mk(1, 5'd1, 0, 5'd0, 0, 5'd0, 0, 0, 0), a);
            mk_ent(mk(1, 5'd2, 0, 5'd0, 0, 5'd0, 0, 0, 0), b);
            tick(1'b1, (i != 2), a, b, 4'b0010, 1'b0);
        end
        n_cmp++; if (out_valid1 !== 1'b1) begin n_err++; $display("FAIL flush_pre valid1: got %b want 1", out_valid1); end
        mk_ent(mk(1, 5'd3, 0, 5'd0, 0, 5'd0, 0, 0, 0), a);
        mk_ent(mk(1, 5'd4, 0, 5'd0, 0, 5'd0, 0, 0, 0), b);
        tick(1'b1, 1'b1, a, b, 4'b0000, 1'b1);
        n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL flush valid1: got %b want 0", out_valid1); end
        n_cmp++; if (issue_mode !== 1'b0) begin n_err++; $display("FAIL flush issue_mode: got %b want 0", issue_mode); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush in_ready: got %b want 1", in_ready); end
        mk_ent(mk(1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 0, 0), a);
        tick(1'b1, 1'b0, a, z, 4'b0000, 1'b0);
        n_cmp++; if (out_pc1 !== a.pc) begin n_err++; $display("FAIL flush_refill pc1: got %h want %h", out_pc1, a.pc); end
        drain();
    endtask

    task automatic test_rst_mid();
        ent_t a, b;
        for (int unsigned i = 0; i < 2; i++) begin
            mk_ent(mk(1, 5'd6, 0, 5'd0, 0, 5'd0, 0, 0, 0), a);
            mk_ent(mk(1, 5'd7, 0, 5'd0, 0, 5'd0, 0, 0, 0), b);
            tick(1'b1, 1'b1, a, b, 4'b0010, 1'b0);
        end
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid in_ready: got %b want 0", in_ready); end
        mk_ent(mk(1, 5'd8, 0, 5'd0, 0, 5'd0, 0, 0, 0), a);
        mk_ent(mk(1, 5'd9, 0, 5'd0, 0, 5'd0, 0, 0, 0), b);
        tick(1'b1, 1'b1, a, b, 4'b0000, 1'b0);
        n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL rst_mid valid1: got %b want 0", out_valid1); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid release in_ready: got %b want 1", in_ready); end
        mk_ent(mk(1, 5'd10, 0, 5'd0, 0, 5'd0, 0, 0, 0), a);
        tick(1'b1, 1'b0, a, z, 4'b0000, 1'b0);
        n_cmp++; if (out_pc1 !== a.pc) begin n_err++; $display("FAIL rst_mid refill pc1: got %h want %h", out_pc1, a.pc); end
        drain();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_dual_alu();
        test_raw();
        test_zero_reg();
        test_pairs();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
